// File: rtl/fp_issue_pkg.sv
// rtl/fp_issue_pkg.sv - shared constants and helpers for the FP-unit issue adapters
// Used by fp_cmp_issue and the sibling add/mul/convert issuers.
//   FP32_W          : IEEE-754 single-precision operand width
//   FP_LATENCY_DEF  : default compare-unit latency in cycles
//   FP_DEPTH_DEF    : default result FIFO depth, which is also the credit limit
//   FP_TAG_W_DEF    : default request tag width
//   ptr_w()         : FIFO pointer width for a given depth, never less than 1 bit
package fp_issue_pkg;

    localparam int FP32_W         = 32;
    localparam int FP_LATENCY_DEF = 2;
    localparam int FP_DEPTH_DEF   = 4;
    localparam int FP_TAG_W_DEF   = 8;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fp_cmp_issue_if.sv
// rtl/fp_cmp_issue_if.sv - request, compare-unit and result signals of the compare issuer
// Signals:
//   in_valid/in_ready/in_a/in_b/in_tag   : request channel (producer -> issuer)
//   fp_a/fp_b/fp_q                       : operands to and result from the compare unit
//   out_valid/out_ready/out_lt/out_tag   : result channel (issuer -> consumer)
//   busy                                 : any operation in flight or buffered
// Modports: slave = the issuer, master = the surrounding system.
interface fp_cmp_issue_if
    import fp_issue_pkg::*;
#(
    parameter int TAG_W = FP_TAG_W_DEF
) ();

    logic              in_valid;
    logic              in_ready;
    logic [FP32_W-1:0] in_a;
    logic [FP32_W-1:0] in_b;
    logic [TAG_W-1:0]  in_tag;
    logic [FP32_W-1:0] fp_a;
    logic [FP32_W-1:0] fp_b;
    logic              fp_q;
    logic              out_valid;
    logic              out_ready;
    logic              out_lt;
    logic [TAG_W-1:0]  out_tag;
    logic              busy;

    modport slave (
        input  in_valid, in_a, in_b, in_tag, fp_q, out_ready,
        output in_ready, fp_a, fp_b, out_valid, out_lt, out_tag, busy
    );

    modport master (
        output in_valid, in_a, in_b, in_tag, fp_q, out_ready,
        input  in_ready, fp_a, fp_b, out_valid, out_lt, out_tag, busy
    );

endinterface

// File: rtl/fp_result_fifo.sv
// rtl/fp_result_fifo.sv - show-ahead result FIFO with registered count
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   wr_en, wr_data    : push one entry (ignored when full)
//   rd_en             : pop the head entry (ignored when empty)
//   rd_data           : head entry, valid whenever empty is low
//   empty             : no entries held
module fp_result_fifo
    import fp_issue_pkg::*;
#(
    parameter int DEPTH = FP_DEPTH_DEF,
    parameter int W     = 1 + FP_TAG_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_wr, do_rd;

    assign do_wr   = wr_en && (cnt_q != FULL_CNT);
    assign do_rd   = rd_en && (cnt_q != '0);
    assign empty   = (cnt_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    // Pointers wrap explicitly so non-power-of-two depths work.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_wr) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        if (do_rd) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        if (do_wr && !do_rd) cnt_d = cnt_q + CNT_W'(1);
        if (!do_wr && do_rd) cnt_d = cnt_q - CNT_W'(1);
    end

    // Storage is cleared on reset so the head reads as zero while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (do_wr) mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Credits upstream must make a push into a full FIFO impossible.
    always_ff @(posedge clk) begin
        if (rst_n) assert (!(wr_en && cnt_q == FULL_CNT));
    end

endmodule

// File: rtl/fp_cmp_issue.sv
// rtl/fp_cmp_issue.sv - issue adapter for the fixed-latency FP less-than unit
// Ports:
//   clk     : clock
//   areset  : asynchronous active-low reset
//   bus     : fp_cmp_issue_if.slave (request, compare-unit and result signals, busy)
// Requests are passed straight to the compare unit; a {valid, tag} shadow
// pipeline of LATENCY stages marks which fp_q samples belong to accepted
// requests, and those results are buffered in a FIFO. The credit counter occ
// reserves a FIFO slot per accepted request, because the unit cannot stall.
module fp_cmp_issue
    import fp_issue_pkg::*;
#(
    parameter int LATENCY = FP_LATENCY_DEF,
    parameter int DEPTH   = FP_DEPTH_DEF,
    parameter int TAG_W   = FP_TAG_W_DEF
) (
    input  logic          clk,
    input  logic          areset,
    fp_cmp_issue_if.slave bus
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic             lt;
        logic [TAG_W-1:0] tag;
    } result_t;

    logic [OCC_W-1:0] occ_q, occ_d;
    logic             issue, drain, fifo_empty;
    logic [LATENCY-1:0] sv_q;
    logic [TAG_W-1:0] st_q [LATENCY];
    result_t          wr_res, rd_res;

    // Registered occupancy only: no path from out_ready to in_ready.
    assign bus.in_ready = (occ_q < OCC_W'(DEPTH));
    assign issue        = bus.in_valid && bus.in_ready;
    assign drain        = !fifo_empty && bus.out_ready;

    assign bus.fp_a = bus.in_a;
    assign bus.fp_b = bus.in_b;

    always_comb begin
        occ_d = occ_q;
        if (issue && !drain) occ_d = occ_q + OCC_W'(1);
        if (!issue && drain) occ_d = occ_q - OCC_W'(1);
    end

    // Stage k holds the request sampled by the unit k edges ago, so the
    // last stage lines up with the unit's current fp_q.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            occ_q <= '0;
            sv_q  <= '0;
            for (int i = 0; i < LATENCY; i++) st_q[i] <= '0;
        end else begin
            occ_q   <= occ_d;
            sv_q[0] <= issue;
            st_q[0] <= bus.in_tag;
            for (int i = 1; i < LATENCY; i++) begin
                sv_q[i] <= sv_q[i-1];
                st_q[i] <= st_q[i-1];
            end
        end
    end

    assign wr_res.lt  = bus.fp_q;
    assign wr_res.tag = st_q[LATENCY-1];

    fp_result_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(result_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (areset),
        .wr_en   (sv_q[LATENCY-1]),
        .wr_data (wr_res),
        .rd_en   (drain),
        .rd_data (rd_res),
        .empty   (fifo_empty)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_lt    = rd_res.lt;
    assign bus.out_tag   = rd_res.tag;
    assign bus.busy      = (occ_q != '0);

endmodule

// File: tb/tb_fp_cmp_issue.sv
// tb/tb_fp_cmp_issue.sv - self-checking bench for fp_cmp_issue
module tb_fp_cmp_issue;
    import fp_issue_pkg::*;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int TAG_W = 8;

    localparam logic [31:0] F_ONE  = 32'h3F800000;
    localparam logic [31:0] F_1P5  = 32'h3FC00000;
    localparam logic [31:0] F_TWO  = 32'h40000000;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  tag;
        logic        lt;
    } vec_t;

    typedef struct packed {
        logic       lt;
        logic [7:0] tag;
    } exp_t;

    logic clk    = 1'b0;
    logic areset = 1'b0;
    always #5 clk = ~clk;

    fp_cmp_issue_if #(.TAG_W(TAG_W)) bus ();

    fp_cmp_issue #(
        .LATENCY (LAT),
        .DEPTH   (DEPTH),
        .TAG_W   (TAG_W)
    ) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus.slave)
    );

    function automatic logic fp_lt(input logic [31:0] a, input logic [31:0] b);
        logic a_nan, b_nan;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        if (a_nan || b_nan) return 1'b0;
        if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return 1'b0;
        if (a[31] != b[31]) return a[31];
        if (!a[31]) return a[30:0] < b[30:0];
        return a[30:0] > b[30:0];
    endfunction

    // Compare unit model: fixed latency, samples every edge, no reset, no stall.
    logic [LAT-1:0] cmp_pipe;
    always @(posedge clk) cmp_pipe <= {cmp_pipe[LAT-2:0], fp_lt(bus.fp_a, bus.fp_b)};
    assign bus.fp_q = cmp_pipe[LAT-1];

    int   total = 0;
    int   bad   = 0;
    int   issued;
    int   drained;
    exp_t sb[$];
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // One clock: model checks, scoreboard push/pop, then advance to just after the edge.
    task automatic step(input logic exp_lt);
        exp_t e;
        check("in_ready_vs_model", {31'd0, bus.in_ready}, {31'd0, sb.size() < DEPTH});
        check("busy_vs_model", {31'd0, bus.busy}, {31'd0, sb.size() != 0});
        if (bus.out_valid && bus.out_ready) begin
            check("result_expected", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_lt", {31'd0, bus.out_lt}, {31'd0, e.lt});
                check("out_tag", {24'd0, bus.out_tag}, {24'd0, e.tag});
            end
            drained++;
        end
        if (bus.in_valid && bus.in_ready) begin
            sb.push_back({exp_lt, bus.in_tag});
            issued++;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick_fp();
        case ($urandom_range(0, 7))
            0:       return 32'h7FC00000;
            1:       return 32'h80000000;
            2:       return 32'h00000000;
            3:       return 32'hFF800000;
            4:       return 32'h7F800000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vecs[0] = '{32'h3F800000, 32'h40000000, 8'h11, 1'b1};
        vecs[1] = '{32'h40000000, 32'h3F800000, 8'h12, 1'b0};
        vecs[2] = '{32'h7FC00000, 32'h3F800000, 8'h13, 1'b0};
        vecs[3] = '{32'h80000000, 32'h00000000, 8'h14, 1'b0};
        vecs[4] = '{32'hFF800000, 32'h7F800000, 8'h15, 1'b1};
        vecs[5] = '{32'hBF800000, 32'hC0000000, 8'h16, 1'b0};
        vecs[6] = '{32'hC0000000, 32'hBF800000, 8'h17, 1'b1};
        vecs[7] = '{32'h3F800000, 32'h3F800000, 8'h18, 1'b0};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        issued        = 0;
        drained       = 0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_out_lt", {31'd0, bus.out_lt}, 32'd0);
        check("rst_out_tag", {24'd0, bus.out_tag}, 32'd0);
        areset = 1'b1;
        @(posedge clk);
        #1;

        // Single ops from the vector table, with latency
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_a     = vecs[i].a;
            bus.in_b     = vecs[i].b;
            bus.in_tag   = vecs[i].tag;
            bus.in_valid = 1'b1;
            check("vec_in_ready", {31'd0, bus.in_ready}, 32'd1);
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            check("vec_lat1_valid", {31'd0, bus.out_valid}, 32'd0);
            @(posedge clk);
            #1;
            check("vec_lat2_valid", {31'd0, bus.out_valid}, 32'd0);
            @(posedge clk);
            #1;
            check("vec_lat3_valid", {31'd0, bus.out_valid}, 32'd1);
            check("vec_lt", {31'd0, bus.out_lt}, {31'd0, vecs[i].lt});
            check("vec_tag", {24'd0, bus.out_tag}, {24'd0, vecs[i].tag});
            @(posedge clk);
            #1;
            check("vec_drained", {31'd0, bus.out_valid}, 32'd0);
            check("vec_busy", {31'd0, bus.busy}, 32'd0);
        end

        // Back-to-back: 16 issues, full throughput
        issued  = 0;
        drained = 0;
        for (int i = 0; i < 16; i++) begin
            bus.in_a     = i[0] ? F_ONE : F_TWO;
            bus.in_b     = F_1P5;
            bus.in_tag   = 8'(i);
            bus.in_valid = 1'b1;
            check("b2b_in_ready", {31'd0, bus.in_ready}, 32'd1);
            step(i[0]);
        end
        bus.in_valid = 1'b0;
        repeat (6) step(1'b0);
        check("b2b_issued", issued, 32'd16);
        check("b2b_drained", drained, 32'd16);

        // Backpressure: credits stop at DEPTH, one drain frees one credit
        issued        = 0;
        drained       = 0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.in_a   = k[0] ? F_ONE : F_TWO;
            bus.in_b   = F_1P5;
            bus.in_tag = 8'(8'h20 + k);
            step(k[0]);
        end
        check("bp_accepted", issued, 32'd4);
        check("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
        bus.in_a      = F_ONE;
        bus.in_tag    = 8'h30;
        bus.out_ready = 1'b1;
        step(1'b1);
        bus.out_ready = 1'b0;
        check("bp_drained_one", drained, 32'd1);
        check("bp_in_ready_back", {31'd0, bus.in_ready}, 32'd1);
        step(1'b1);
        check("bp_issued_fifth", issued, 32'd5);
        check("bp_in_ready_full_again", {31'd0, bus.in_ready}, 32'd0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (8) step(1'b0);
        check("bp_all_drained", drained, 32'd5);
        check("bp_sb_empty", sb.size(), 32'd0);

        // Reset mid-flight
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = k[0] ? F_ONE : F_TWO;
            bus.in_b     = F_1P5;
            bus.in_tag   = 8'(8'h40 + k);
            step(k[0]);
        end
        bus.in_valid = 1'b0;
        step(1'b0);
        areset = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        sb.delete();
        @(posedge clk);
        #1;
        areset = 1'b1;
        repeat (6) begin
            check("midrst_stale_valid", {31'd0, bus.out_valid}, 32'd0);
            step(1'b0);
        end

        // Random traffic against the scoreboard
        issued  = 0;
        drained = 0;
        for (int c = 0; c < 10000; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_a      = pick_fp();
            bus.in_b      = pick_fp();
            bus.in_tag    = 8'($urandom);
            step(fp_lt(bus.in_a, bus.in_b));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) step(1'b0);
        check("rand_sb_empty", sb.size(), 32'd0);
        check("rand_count_match", drained, issued);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
